move_jogadores: RTL

MOVE_JOGADORES -- requirements
Module: move_jogadores

---
 rtl/move_jogadores_if.sv | 25 ++
 rtl/move_jogadores.sv | 110 +++++++++++
 2 files changed

// File: rtl/move_jogadores_if.sv
// move_jogadores_if: button inputs and game-state outputs of the two-player board mover
interface move_jogadores_if;
    logic       botao1;
    logic       botao2;
    logic       botao3;
    logic       botao4;
    logic [3:0] memoria1;
    logic [3:0] memoria2;
    logic       vez;
    logic [2:0] passo;
    logic       movimento;
    logic       bloqueado;
    logic       fim;
    logic       vencedor;

    modport master (
        output botao1, botao2, botao3, botao4,
        input  memoria1, memoria2, vez, passo, movimento, bloqueado, fim, vencedor
    );

    modport slave (
        input  botao1, botao2, botao3, botao4,
        output memoria1, memoria2, vez, passo, movimento, bloqueado, fim, vencedor
    );
endinterface

// File: rtl/move_jogadores.sv
// move_jogadores: turn-based two-player board mover with step sequence, saturation, collision and win detection
module move_jogadores (
    input logic            clk,
    input logic            rst,
    move_jogadores_if.slave bus
);
    typedef enum logic {S_PLAY, S_OVER} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_s3;
    logic [3:0] r_m1;
    logic [3:0] r_m2;
    logic [2:0] r_idx;
    logic       r_vez;
    logic       r_mov;
    logic       r_bloq;
    logic       r_venc;

    logic [3:0] w_edge;
    logic       w_adv;
    logic       w_ret;
    logic       w_accept;
    logic       w_up;
    logic [2:0] w_passo;
    logic [3:0] w_pos;
    logic [3:0] w_opp;
    logic [4:0] w_sum;
    logic [4:0] w_dif;
    logic [3:0] w_tgt;
    logic       w_blk;
    logic [3:0] w_new;
    logic       w_win;

    // bit 0..3 of the edge vector correspond to botao1..botao4
    assign w_edge   = r_s2 & ~r_s3;
    assign w_adv    = r_vez ? w_edge[0] : w_edge[2];
    assign w_ret    = r_vez ? w_edge[1] : w_edge[3];
    // pressing both buttons of the active player together cancels the move
    assign w_accept = (r_state == S_PLAY) & (w_adv ^ w_ret);
    // player 1 advances upward, player 2 advances downward
    assign w_up     = r_vez ? w_ret : w_adv;
    assign w_passo  = (r_idx == 3'd0 || r_idx == 3'd5) ? 3'd1 :
                      (r_idx == 3'd1 || r_idx == 3'd4) ? 3'd2 :
                      (r_idx == 3'd2 || r_idx == 3'd3) ? 3'd3 : 3'd0;
    assign w_pos    = r_vez ? r_m2 : r_m1;
    assign w_opp    = r_vez ? r_m1 : r_m2;
    assign w_sum    = {1'b0, w_pos} + {2'b00, w_passo};
    assign w_dif    = {1'b0, w_pos} - {2'b00, w_passo};
    assign w_tgt    = w_up ? (w_sum[4] ? 4'd15 : w_sum[3:0]) : (w_dif[4] ? 4'd0 : w_dif[3:0]);
    assign w_blk    = w_tgt == w_opp;
    assign w_new    = w_blk ? w_pos : w_tgt;
    assign w_win    = w_accept & (r_vez ? (w_new == 4'd0) : (w_new == 4'd15));

    // game state register: playing until someone reaches the far end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_PLAY;
        else     r_state <= w_next;
    end

    // next game state: a winning move ends the game; only reset restarts it
    always_comb begin
        w_next = r_state;
        if (r_state == S_PLAY && w_win) w_next = S_OVER;
    end

    // game state outputs
    always_comb begin
        bus.fim = r_state == S_OVER;
    end

    // synchronizers, edge flops, positions, turn, step index and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_m1   <= 4'd0;
            r_m2   <= 4'd15;
            r_idx  <= 3'd0;
            r_vez  <= 1'b0;
            r_mov  <= 1'b0;
            r_bloq <= 1'b0;
            r_venc <= 1'b0;
        end else begin
            r_s1   <= {bus.botao4, bus.botao3, bus.botao2, bus.botao1};
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_mov  <= w_accept;
            r_bloq <= w_accept & w_blk;
            if (w_accept) begin
                r_vez <= ~r_vez;
                r_idx <= (r_idx == 3'd6) ? 3'd0 : r_idx + 3'd1;
                if (r_vez) r_m2 <= w_new;
                else       r_m1 <= w_new;
            end
            if (w_win) r_venc <= r_vez;
        end
    end

    assign bus.memoria1  = r_m1;
    assign bus.memoria2  = r_m2;
    assign bus.vez       = r_vez;
    assign bus.passo     = w_passo;
    assign bus.movimento = r_mov;
    assign bus.bloqueado = r_bloq;
    assign bus.vencedor  = r_venc;
endmodule
